// File: rtl/vdp_ctrl_ifce_if.sv
// rtl/vdp_ctrl_ifce_if.sv - CPU port and VRAM access bus bundle for vdp_ctrl_ifce
//
// Signals:
//   wr_tick, rd_tick   one-cycle CPU write/read strobes
//   mode               0 = data port, 1 = control/status port
//   din, dout          CPU write data / CPU read data
//   vram_addr          current VRAM address
//   vram_wr            one-cycle VRAM write strobe, with vram_wdata
//   vram_rd            one-cycle VRAM read (prefetch) strobe
//   vram_rvalid        one-cycle strobe marking vram_rdata valid
//
// Modports:
//   master   CPU bus tick generator plus VRAM arbiter side
//   slave    vdp_ctrl_ifce side
interface vdp_ctrl_ifce_if;
    logic        wr_tick;
    logic        rd_tick;
    logic        mode;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [13:0] vram_addr;
    logic        vram_wr;
    logic [7:0]  vram_wdata;
    logic        vram_rd;
    logic        vram_rvalid;
    logic [7:0]  vram_rdata;

    modport master (
        output wr_tick, rd_tick, mode, din, vram_rvalid, vram_rdata,
        input  dout, vram_addr, vram_wr, vram_wdata, vram_rd
    );

    modport slave (
        input  wr_tick, rd_tick, mode, din, vram_rvalid, vram_rdata,
        output dout, vram_addr, vram_wr, vram_wdata, vram_rd
    );
endinterface

// File: rtl/vdp_ctrl_ifce.sv
// rtl/vdp_ctrl_ifce.sv - VDP CPU control/data port with VRAM read-ahead and status register
//
// Parameters:
//   NUM_REGS   number of write-only VDP registers (1..64)
//   AUTO_INC   1 = data-port accesses post-increment the VRAM address
//
// Ports:
//   clk          pixel clock, all logic on the rising edge
//   reset        synchronous, active-low
//   bus          slave side of the CPU port / VRAM bus bundle
//   regs         flattened register file, reg n at [8n+7:8n]
//   frame_tick   sets status F (vertical blank)
//   coinc_tick   sets status C (sprite coincidence)
//   fifth_tick   sets status 5S and latches fifth_num while 5S is clear
//   fifth_num    fifth-sprite number
//   irq          F gated by register 1 bit 5
module vdp_ctrl_ifce #(
    parameter int NUM_REGS = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    vdp_ctrl_ifce_if.slave        bus,
    output logic [8*NUM_REGS-1:0] regs,
    input  logic                  frame_tick,
    input  logic                  coinc_tick,
    input  logic                  fifth_tick,
    input  logic [4:0]            fifth_num,
    output logic                  irq
);
    localparam int         RW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    // Control port byte pairing: first byte is latched into lo_q, second
    // byte carries the command code in bits 7:6.
    typedef enum logic {
        CTL_FIRST  = 1'b0,
        CTL_SECOND = 1'b1
    } ctl_state_t;

    ctl_state_t  state_q;
    ctl_state_t  state_d;

    logic [7:0]  reg_q [NUM_REGS];
    logic [7:0]  lo_q;
    logic [13:0] addr_q;
    logic        inc_pend_q;
    logic [7:0]  buf_q;
    logic [7:0]  dout_q;
    logic [7:0]  wdata_q;
    logic        vram_wr_q;
    logic        vram_rd_q;
    logic        f_q;
    logic        s5_q;
    logic        c_q;
    logic [4:0]  fnum_q;

    logic [7:0]  din;
    logic        wr_ctrl;
    logic        wr_data;
    logic        rd_data;
    logic        rd_stat;
    logic        second_byte;
    logic        reg_wr;
    logic        addr_set;
    logic        prefetch_set;
    logic [13:0] addr_next;

    assign din = bus.din;

    // A write in the same cycle as a read wins; the read is dropped.
    assign wr_ctrl = bus.wr_tick & bus.mode;
    assign wr_data = bus.wr_tick & ~bus.mode;
    assign rd_data = bus.rd_tick & ~bus.wr_tick & ~bus.mode;
    assign rd_stat = bus.rd_tick & ~bus.wr_tick & bus.mode;

    assign second_byte  = wr_ctrl & (state_q == CTL_SECOND);
    assign reg_wr       = second_byte & (din[7:6] == 2'b10)
                          & ({1'b0, din[5:0]} < NUM_REGS_W);
    assign addr_set     = second_byte & ~din[7];
    assign prefetch_set = second_byte & (din[7:6] == 2'b00);

    // The increment for an access lands one cycle after the tick so that the
    // strobe cycle still presents the pre-increment address. 14-bit
    // arithmetic gives the 0x3FFF -> 0x0000 wrap for free.
    assign addr_next = inc_pend_q ? (addr_q + 14'd1) : addr_q;

    always_comb begin
        state_d = state_q;
        if (wr_ctrl) begin
            state_d = (state_q == CTL_FIRST) ? CTL_SECOND : CTL_FIRST;
        end else if (wr_data || rd_data || rd_stat) begin
            state_d = CTL_FIRST;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= CTL_FIRST;
            lo_q       <= 8'h00;
            addr_q     <= 14'h0000;
            inc_pend_q <= 1'b0;
            buf_q      <= 8'h00;
            dout_q     <= 8'h00;
            wdata_q    <= 8'h00;
            vram_wr_q  <= 1'b0;
            vram_rd_q  <= 1'b0;
            f_q        <= 1'b0;
            s5_q       <= 1'b0;
            c_q        <= 1'b0;
            fnum_q     <= 5'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            vram_wr_q <= wr_data;
            vram_rd_q <= rd_data | prefetch_set;

            if (wr_ctrl && (state_q == CTL_FIRST)) begin
                lo_q <= din;
            end

            if (reg_wr) begin
                reg_q[din[RW-1:0]] <= lo_q;
            end

            // A new address setup overrides any increment still pending
            // from the previous access.
            if (addr_set) begin
                addr_q     <= {din[5:0], lo_q};
                inc_pend_q <= prefetch_set & AUTO_INC;
            end else if (wr_data || rd_data) begin
                addr_q     <= addr_next;
                inc_pend_q <= AUTO_INC;
            end else begin
                addr_q     <= addr_next;
                inc_pend_q <= 1'b0;
            end

            if (wr_data) begin
                wdata_q <= din;
            end

            // Written data also becomes the read-ahead value; prefetch
            // returns are guaranteed not to collide with a data-port tick.
            if (wr_data) begin
                buf_q <= din;
            end else if (bus.vram_rvalid) begin
                buf_q <= bus.vram_rdata;
            end

            if (rd_data) begin
                dout_q <= buf_q;
            end else if (rd_stat) begin
                dout_q <= {f_q, s5_q, c_q, fnum_q};
            end

            // Clear-on-read, but a set event in the same cycle wins.
            f_q  <= (f_q  & ~rd_stat) | frame_tick;
            s5_q <= (s5_q & ~rd_stat) | fifth_tick;
            c_q  <= (c_q  & ~rd_stat) | coinc_tick;
            if (fifth_tick && !s5_q) begin
                fnum_q <= fifth_num;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.vram_addr  = addr_q;
    assign bus.vram_wr    = vram_wr_q;
    assign bus.vram_wdata = wdata_q;
    assign bus.vram_rd    = vram_rd_q;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_regs
            assign regs[8*g +: 8] = reg_q[g];
        end
        if (NUM_REGS > 1) begin : g_irq
            assign irq = f_q & reg_q[1][5];
        end else begin : g_no_irq
            assign irq = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_vdp_ctrl_ifce.sv
// tb/tb_vdp_ctrl_ifce.sv - self-checking bench for vdp_ctrl_ifce (AUTO_INC=1 and AUTO_INC=0 instances)
module tb_vdp_ctrl_ifce;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       wr_tick, rd_tick, mode;
    logic [7:0] din;
    logic       frame_tick, coinc_tick, fifth_tick;
    logic [4:0] fifth_num;
    logic [63:0] regs_a, regs_b;
    logic        irq_a, irq_b;

    int n_chk = 0;
    int n_err = 0;

    vdp_ctrl_ifce_if bus_a ();
    vdp_ctrl_ifce_if bus_b ();

    assign bus_a.wr_tick = wr_tick;
    assign bus_a.rd_tick = rd_tick;
    assign bus_a.mode    = mode;
    assign bus_a.din     = din;
    assign bus_b.wr_tick = wr_tick;
    assign bus_b.rd_tick = rd_tick;
    assign bus_b.mode    = mode;
    assign bus_b.din     = din;

    vdp_ctrl_ifce #(.NUM_REGS(8), .AUTO_INC(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .regs(regs_a),
        .frame_tick(frame_tick), .coinc_tick(coinc_tick),
        .fifth_tick(fifth_tick), .fifth_num(fifth_num), .irq(irq_a)
    );

    vdp_ctrl_ifce #(.NUM_REGS(8), .AUTO_INC(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .regs(regs_b),
        .frame_tick(frame_tick), .coinc_tick(coinc_tick),
        .fifth_tick(fifth_tick), .fifth_num(fifth_num), .irq(irq_b)
    );

    // ---------------- VRAM responders (one memory per instance) ----------
    logic [7:0] phys  [2][16384];
    bit         wrote [2][16384];

    function automatic logic [7:0] init_val(logic [13:0] a);
        return 8'(8'h5A + 8'h11 * a[7:0]);
    endfunction

    function automatic logic [7:0] phys_rd(int k, logic [13:0] a);
        return wrote[k][a] ? phys[k][a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        bus_a.vram_rvalid <= bus_a.vram_rd;
        bus_a.vram_rdata  <= phys_rd(0, bus_a.vram_addr);
        if (bus_a.vram_wr) begin
            phys[0][bus_a.vram_addr]  <= bus_a.vram_wdata;
            wrote[0][bus_a.vram_addr] <= 1'b1;
        end
        bus_b.vram_rvalid <= bus_b.vram_rd;
        bus_b.vram_rdata  <= phys_rd(1, bus_b.vram_addr);
        if (bus_b.vram_wr) begin
            phys[1][bus_b.vram_addr]  <= bus_b.vram_wdata;
            wrote[1][bus_b.vram_addr] <= 1'b1;
        end
    end

    // ---------------- reference model ------------------------------------
    typedef struct {
        bit          is_wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t exp_q0[$];
    ev_t exp_q1[$];

    logic [7:0]  m_regs [8];
    logic [7:0]  m_lo;
    bit          m_tog;
    logic [13:0] m_addr [2];
    logic [7:0]  m_buf  [2];
    logic [7:0]  m_dout [2];
    bit          m_f, m_s, m_c;
    logic [4:0]  m_fn;
    logic [7:0]  m_mem  [2][16384];
    bit          m_wrt  [2][16384];

    function automatic logic [7:0] model_mem(int k, logic [13:0] a);
        return m_wrt[k][a] ? m_mem[k][a] : init_val(a);
    endfunction

    function automatic logic [63:0] model_regs();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_lo = 8'h00; m_tog = 1'b0;
        m_f = 1'b0; m_s = 1'b0; m_c = 1'b0; m_fn = 5'h00;
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 14'h0000; m_buf[k] = 8'h00; m_dout[k] = 8'h00;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // One VRAM access at the current address; instance 0 auto-increments.
    task automatic access(int k, bit is_wr, logic [7:0] d);
        ev_t e;
        e.is_wr = is_wr;
        e.addr  = m_addr[k];
        e.data  = is_wr ? d : 8'h00;
        if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        if (is_wr) begin
            m_mem[k][e.addr] = d;
            m_wrt[k][e.addr] = 1'b1;
            m_buf[k] = d;
        end else begin
            m_buf[k] = model_mem(k, e.addr);
        end
        if (k == 0) m_addr[k] = m_addr[k] + 14'd1;
    endtask

    task automatic model_cycle(bit wr, bit rd, bit md, logic [7:0] d,
                               bit ft, bit ct, bit st, logic [4:0] fn);
        bit rstat;
        bit rdat;
        rstat = rd && !wr && md;
        rdat  = rd && !wr && !md;
        if (rstat) for (int k = 0; k < 2; k++) m_dout[k] = {m_f, m_s, m_c, m_fn};
        if (st && !m_s) m_fn = fn;
        m_f = (m_f && !rstat) || ft;
        m_s = (m_s && !rstat) || st;
        m_c = (m_c && !rstat) || ct;
        if (wr && md) begin
            if (!m_tog) begin
                m_lo  = d;
                m_tog = 1'b1;
            end else begin
                m_tog = 1'b0;
                case (d[7:6])
                    2'b10: if (d[5:0] < 6'd8) m_regs[d[2:0]] = m_lo;
                    2'b01: for (int k = 0; k < 2; k++) m_addr[k] = {d[5:0], m_lo};
                    2'b00: for (int k = 0; k < 2; k++) begin
                        m_addr[k] = {d[5:0], m_lo};
                        access(k, 1'b0, 8'h00);
                    end
                    default: ;
                endcase
            end
        end else if (wr) begin
            m_tog = 1'b0;
            for (int k = 0; k < 2; k++) access(k, 1'b1, d);
        end else if (rdat) begin
            m_tog = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_dout[k] = m_buf[k];
                access(k, 1'b0, 8'h00);
            end
        end else if (rstat) begin
            m_tog = 1'b0;
        end
    endtask

    // ---------------- checking helpers -----------------------------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_one(int k, logic wr, logic rd, logic [13:0] a, logic [7:0] d);
        ev_t e;
        if (wr === 1'b1 || rd === 1'b1) begin
            n_chk++;
            if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                n_err++;
                $display("FAIL strobe%0d: got unexpected wr=%0b rd=%0b addr %0h expected none", k, wr, rd, a);
            end else begin
                e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (wr !== e.is_wr || rd !== !e.is_wr || a !== e.addr || (e.is_wr && d !== e.data)) begin
                    n_err++;
                    $display("FAIL strobe%0d: got wr=%0b rd=%0b addr %0h data %0h expected wr=%0b addr %0h data %0h",
                             k, wr, rd, a, d, e.is_wr, e.addr, e.data);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon_one(0, bus_a.vram_wr, bus_a.vram_rd, bus_a.vram_addr, bus_a.vram_wdata);
            mon_one(1, bus_b.vram_wr, bus_b.vram_rd, bus_b.vram_addr, bus_b.vram_wdata);
        end
    end

    task automatic check_all(string tag);
        logic [63:0] mr;
        mr = model_regs();
        chk({tag, "_regs_a"}, regs_a, mr);
        chk({tag, "_regs_b"}, regs_b, mr);
        chk({tag, "_dout_a"}, 64'(bus_a.dout), 64'(m_dout[0]));
        chk({tag, "_dout_b"}, 64'(bus_b.dout), 64'(m_dout[1]));
        chk({tag, "_irq_a"}, 64'(irq_a), 64'(m_f & m_regs[1][5]));
        chk({tag, "_irq_b"}, 64'(irq_b), 64'(m_f & m_regs[1][5]));
        chk({tag, "_addr_a"}, 64'(bus_a.vram_addr), 64'(m_addr[0]));
        chk({tag, "_addr_b"}, 64'(bus_b.vram_addr), 64'(m_addr[1]));
    endtask

    // ---------------- stimulus helpers (called at a negedge) -------------
    task automatic cyc(input bit wr, input bit rd, input bit md, input logic [7:0] d,
                       input bit ft = 1'b0, input bit ct = 1'b0,
                       input bit st = 1'b0, input logic [4:0] fn = 5'h00);
        wr_tick = wr; rd_tick = rd; mode = md; din = d;
        frame_tick = ft; coinc_tick = ct; fifth_tick = st; fifth_num = fn;
        model_cycle(wr, rd, md, d, ft, ct, st, fn);
        @(negedge clk);
        wr_tick = 1'b0; rd_tick = 1'b0;
        frame_tick = 1'b0; coinc_tick = 1'b0; fifth_tick = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset(string tag);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk({tag, "_regs"}, regs_a | regs_b, 64'h0);
        chk({tag, "_outs_a"}, 64'({bus_a.dout, bus_a.vram_addr, bus_a.vram_wr, bus_a.vram_rd, irq_a}), 64'h0);
        chk({tag, "_outs_b"}, 64'({bus_b.dout, bus_b.vram_addr, bus_b.vram_wr, bus_b.vram_rd, irq_b}), 64'h0);
        reset = 1'b1;
    endtask

    typedef struct {
        bit         wr;
        bit         rd;
        bit         md;
        logic [7:0] d;
        int         ri;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[$];

    initial begin
        wr_tick = 1'b0; rd_tick = 1'b0; mode = 1'b0; din = 8'h00;
        frame_tick = 1'b0; coinc_tick = 1'b0; fifth_tick = 1'b0; fifth_num = 5'h00;
        reset = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16384; a++) m_wrt[k][a] = 1'b0;
        @(negedge clk);
        do_reset("reset");

        // Register writes, back-to-back pairs, toggle reset by status read,
        // out-of-range index ignored. Rows run on consecutive cycles.
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'hEE, 0, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h80, 0, 8'hEE});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h33, 3, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h83, 3, 8'h33});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h44, 4, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h84, 4, 8'h44});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h55, 5, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h85, 5, 8'h55});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h22, 2, 8'h00});
        vt.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 2, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h11, 1, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h81, 1, 8'h11});
        vt.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 2, 8'h00});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h99, 0, 8'hEE});
        vt.push_back('{1'b1, 1'b0, 1'b1, 8'h8A, 1, 8'h11});
        vt.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 2, 8'h00});
        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].wr, vt[i].rd, vt[i].md, vt[i].d);
            chk($sformatf("vec%0d_reg%0d", i, vt[i].ri),
                64'(regs_a[8*vt[i].ri +: 8]), 64'(vt[i].exp));
        end
        chk("vec_all_regs", regs_a, 64'h0000_5544_3300_11EE);
        idle(2);
        check_all("vec");

        // Write setup at 0x3FFF, two data writes wrap to 0x0000.
        cyc(1'b1, 1'b0, 1'b1, 8'hFF);
        cyc(1'b1, 1'b0, 1'b1, 8'h7F);
        chk("wrap_setup_addr", 64'(bus_a.vram_addr), 64'h3FFF);
        cyc(1'b1, 1'b0, 1'b0, 8'hA1);
        chk("wrap_wr0_a", 64'({bus_a.vram_wr, bus_a.vram_addr, bus_a.vram_wdata}), 64'({1'b1, 14'h3FFF, 8'hA1}));
        cyc(1'b1, 1'b0, 1'b0, 8'hA2);
        chk("wrap_wr1_a", 64'({bus_a.vram_wr, bus_a.vram_addr, bus_a.vram_wdata}), 64'({1'b1, 14'h0000, 8'hA2}));
        chk("wrap_wr1_b", 64'({bus_b.vram_wr, bus_b.vram_addr, bus_b.vram_wdata}), 64'({1'b1, 14'h3FFF, 8'hA2}));
        idle(1);
        chk("wrap_addr_after_a", 64'(bus_a.vram_addr), 64'h0001);
        idle(2);
        check_all("wrap");

        // Read setup at 0x1000 with prefetch, then two data reads.
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h10);
        chk("pf_rd_a", 64'({bus_a.vram_rd, bus_a.vram_addr}), 64'({1'b1, 14'h1000}));
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pf_read1_a", 64'(bus_a.dout), 64'h5A);
        chk("pf_read1_b", 64'(bus_b.dout), 64'h5A);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("pf_read2_a", 64'(bus_a.dout), 64'h6B);
        chk("pf_read2_b", 64'(bus_b.dout), 64'h5A);
        idle(3);
        check_all("pf");

        // Status flags, irq, clear-on-read, set-wins and fifth latch hold.
        cyc(1'b1, 1'b0, 1'b1, 8'h20);
        cyc(1'b1, 1'b0, 1'b1, 8'h81);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'h07);
        chk("st_irq_set", 64'(irq_a), 64'h1);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("st_read1", 64'(bus_a.dout), 64'hC7);
        chk("st_irq_clr", 64'(irq_a), 64'h0);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("st_read2", 64'(bus_a.dout), 64'h07);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 5'h00);
        chk("st_coinc_read", 64'(bus_a.dout), 64'h07);
        chk("st_coinc_irq", 64'(irq_a), 64'h1);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("st_read3", 64'(bus_a.dout), 64'hA7);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'h03);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'h09);
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("st_fifth_hold", 64'(bus_a.dout), 64'h43);
        idle(2);
        check_all("st");

        // Reset in the middle of a control pair.
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h44);
        do_reset("midrst");
        cyc(1'b1, 1'b0, 1'b1, 8'h33);
        cyc(1'b1, 1'b0, 1'b1, 8'h83);
        chk("midrst_reg3", regs_a, 64'h0000_0000_3300_0000);
        idle(2);
        check_all("midrst");

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            int         sel;
            logic [7:0] d;
            bit         ft, ct, st;
            logic [4:0] fn;
            sel = $urandom_range(0, 9);
            d   = 8'($urandom);
            ft  = ($urandom_range(0, 7) == 0);
            ct  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 7) == 0);
            fn  = 5'($urandom);
            if (sel <= 3 && $urandom_range(0, 1) == 1) d[7:6] = 2'b10;
            case (sel)
                0, 1, 2, 3: cyc(1'b1, 1'b0, 1'b1, d, ft, ct, st, fn);
                4, 5:       cyc(1'b1, 1'b0, 1'b0, d, ft, ct, st, fn);
                6, 7:       cyc(1'b0, 1'b1, 1'b0, d, ft, ct, st, fn);
                8:          cyc(1'b0, 1'b1, 1'b1, d, ft, ct, st, fn);
                default:    cyc(1'b1, 1'b1, 1'($urandom), d, ft, ct, st, fn);
            endcase
            idle(3);
            check_all($sformatf("rnd%0d", i));
        end

        idle(2);
        chk("evq_a_empty", 64'(exp_q0.size()), 64'h0);
        chk("evq_b_empty", 64'(exp_q1.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
